// File: rtl/gcd_lcm_pkg.sv
// Shared types and width helpers for the GCD/LCM engine.
//   gl_state_e   : engine FSM states
//   gl_k_width   : width of the Stein power-of-two counter k (counts 0..DW)
//   gl_cnt_width : width of the divider iteration counter (counts DW..1)
package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GCD  = 3'd1,
    ST_DIV  = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } gl_state_e;

  function automatic int gl_k_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  function automatic int gl_cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/gcd_lcm_div.sv
// Restoring unsigned divider, one quotient bit per cycle, exactly DW cycles.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : load dividend/divisor and begin (one-cycle pulse)
//   i_dividend   : DW-bit dividend
//   i_divisor    : DW-bit divisor (non-zero whenever i_start is used)
//   o_done       : high during the last iteration cycle; results valid next cycle
//   o_quotient   : DW-bit quotient
//   o_remainder  : DW-bit remainder
module gcd_lcm_div
  import gcd_lcm_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_done,
  output logic [DW-1:0] o_quotient,
  output logic [DW-1:0] o_remainder
);

  localparam int CW = gl_cnt_width(DW);

  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [DW:0]   w_shift;
  logic [DW:0]   w_diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // the top bit of w_diff is the borrow (partial remainder < divisor).
  always_comb begin
    w_shift = {r_rem, r_quo[DW-1]};
    w_diff  = w_shift - {1'b0, r_dvs};
  end

  // Iteration registers: quotient bits shift in from the right as dividend bits leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_cnt  <= CW'(DW);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (!w_diff[DW]) begin
        r_rem <= w_diff[DW-1:0];
        r_quo <= {r_quo[DW-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[DW-1:0];
        r_quo <= {r_quo[DW-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done      = r_busy && (r_cnt == CW'(1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/gcd_lcm_div_chk.sv
// Checker for the divider: the dividend is always a multiple of the divisor
// (orig_a / gcd), so the remainder must be zero once a division completes.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_done       : divider last-iteration flag
//   i_remainder  : divider remainder output
module gcd_lcm_div_chk #(
  parameter int DW = 8
) (
  input logic          clk,
  input logic          rst_n,
  input logic          i_done,
  input logic [DW-1:0] i_remainder
);

  logic r_done_d;

  // Delay done by one cycle so the final remainder has been registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= i_done;
    end
  end

  // Remainder of orig_a / gcd must be zero.
  always @(posedge clk) begin
    if (rst_n && r_done_d) begin
      assert (i_remainder == '0);
    end
  end

endmodule

// File: rtl/gcd_lcm_engine.sv
// Iterative GCD/LCM engine: binary (Stein) GCD, then lcm = (a/gcd)*b.
// One operation in flight, valid/ready handshake on both sides.
// Parameters: DW operand width (>=2); LCM_EN 1 = gcd+lcm, 0 = gcd only (lcm_o = 0).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   data_a, data_b      : unsigned operands
//   out_valid/out_ready : result handshake (out_valid held until accepted)
//   gcd_o, lcm_o        : results, held in IDLE until the next result
//   busy_o              : high in any state other than IDLE
module gcd_lcm_engine
  import gcd_lcm_pkg::*;
#(
  parameter int DW     = 8,
  parameter bit LCM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   data_a,
  input  logic [DW-1:0]   data_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   gcd_o,
  output logic [2*DW-1:0] lcm_o,
  output logic            busy_o
);

  localparam int KW = gl_k_width(DW);
  localparam int LW = 2 * DW;

  gl_state_e       r_state;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_orig_a;
  logic [DW-1:0]   r_orig_b;
  logic [KW-1:0]   r_k;
  logic [DW-1:0]   r_g;
  logic [DW-1:0]   r_gcd;
  logic [LW-1:0]   r_lcm;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [DW-1:0]   w_a_nxt;
  logic [DW-1:0]   w_b_nxt;
  logic [KW-1:0]   w_k_nxt;
  logic [DW-1:0]   w_g;
  logic            w_gcd_exit;
  logic            w_zero_op;
  logic            w_div_done;
  logic [DW-1:0]   w_quot;

  assign w_zero_op = (r_orig_a == '0) || (r_orig_b == '0);

  // One Stein step on (a, b, k); exit once either value reaches zero,
  // restoring the common power of two with g = nonzero << k.
  always_comb begin
    w_a_nxt    = r_a;
    w_b_nxt    = r_b;
    w_k_nxt    = r_k;
    w_g        = '0;
    w_gcd_exit = 1'b0;
    if (r_a == '0) begin
      w_gcd_exit = 1'b1;
      w_g        = r_b << r_k;
    end else if (r_b == '0) begin
      w_gcd_exit = 1'b1;
      w_g        = r_a << r_k;
    end else if (!r_a[0] && !r_b[0]) begin
      w_a_nxt = r_a >> 1;
      w_b_nxt = r_b >> 1;
      w_k_nxt = r_k + KW'(1);
    end else if (!r_a[0]) begin
      w_a_nxt = r_a >> 1;
    end else if (!r_b[0]) begin
      w_b_nxt = r_b >> 1;
    end else if (r_a >= r_b) begin
      // both odd: the difference is even, so halve it in the same step
      w_a_nxt = (r_a - r_b) >> 1;
    end else begin
      w_b_nxt = (r_b - r_a) >> 1;
    end
  end

  generate
    if (LCM_EN) begin : g_lcm
      logic          w_div_start;
      logic [DW-1:0] w_rem;

      // Divider is loaded on the GCD exit edge so DIV lasts exactly DW cycles.
      assign w_div_start = (r_state == ST_GCD) && w_gcd_exit && !w_zero_op;

      gcd_lcm_div #(.DW(DW)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_div_start),
        .i_dividend  (r_orig_a),
        .i_divisor   (w_g),
        .o_done      (w_div_done),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
      );

      gcd_lcm_div_chk #(.DW(DW)) u_div_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_done      (w_div_done),
        .i_remainder (w_rem)
      );
    end else begin : g_no_lcm
      assign w_div_done = 1'b0;
      assign w_quot     = '0;
    end
  endgenerate

  // Engine FSM; all handshake and result outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_orig_a    <= '0;
      r_orig_b    <= '0;
      r_k         <= '0;
      r_g         <= '0;
      r_gcd       <= '0;
      r_lcm       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= data_a;
            r_b        <= data_b;
            r_orig_a   <= data_a;
            r_orig_b   <= data_b;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_GCD;
          end
        end
        ST_GCD: begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
          r_k <= w_k_nxt;
          if (w_gcd_exit) begin
            r_g <= w_g;
            if (LCM_EN && !w_zero_op) begin
              r_state <= ST_DIV;
            end else begin
              r_gcd       <= w_g;
              r_lcm       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          // (a/g) * b <= a*b fits in 2*DW bits
          r_lcm       <= LW'(w_quot) * LW'(r_orig_b);
          r_gcd       <= r_g;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign gcd_o     = r_gcd;
  assign lcm_o     = r_lcm;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Directed and random bench for gcd_lcm_engine: an 8-bit gcd+lcm instance and
// a 16-bit gcd-only instance share clock/reset; 'sel' picks the active one.
module tb_gcd_lcm_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  logic [15:0] drv_a = 16'd0;
  logic [15:0] drv_b = 16'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  g8;
  logic [15:0] l8;
  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] g16;
  logic [31:0] l16;

  assign iv8  = drv_valid & ~sel;
  assign or8  = drv_ready & ~sel;
  assign iv16 = drv_valid & sel;
  assign or16 = drv_ready & sel;

  gcd_lcm_engine #(.DW(8), .LCM_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .data_a(drv_a[7:0]), .data_b(drv_b[7:0]), .out_valid(ov8), .out_ready(or8),
    .gcd_o(g8), .lcm_o(l8), .busy_o(busy8)
  );

  gcd_lcm_engine #(.DW(16), .LCM_EN(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .data_a(drv_a), .data_b(drv_b), .out_valid(ov16), .out_ready(or16),
    .gcd_o(g16), .lcm_o(l16), .busy_o(busy16)
  );

  logic        cur_ov, cur_ir, cur_busy;
  logic [15:0] cur_g;
  logic [31:0] cur_l;

  always_comb begin
    cur_ov   = sel ? ov16   : ov8;
    cur_ir   = sel ? ir16   : ir8;
    cur_busy = sel ? busy16 : busy8;
    cur_g    = sel ? g16    : {8'd0, g8};
    cur_l    = sel ? l16    : {16'd0, l8};
  end

  // Euclid reference (deliberately a different algorithm from the DUT)
  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [31:0] ref_lcm(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] g;
    if (a == 16'd0 || b == 16'd0) return 32'd0;
    g = ref_gcd(a, b);
    return 32'(a / g) * 32'(b);
  endfunction

  // Drive one operation on the selected DUT and report what was observed.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] g, output logic [31:0] l, output int lat,
                        output bit to, output bit busy_bad, output bit hold_bad,
                        output bit acc_bad);
    int n;
    to = 1'b0; busy_bad = 1'b0; hold_bad = 1'b0; acc_bad = 1'b0;
    g = 16'd0; l = 32'd0; lat = 0;
    n = 0;
    while (cur_ir !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (cur_ir !== 1'b1) to = 1'b1;
    drv_a = a; drv_b = b; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    n = 0;
    while (cur_ov !== 1'b1 && n < 100) begin
      if (cur_ir !== 1'b0 || cur_busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    if (cur_ov !== 1'b1) to = 1'b1;
    lat = n; g = cur_g; l = cur_l;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (cur_ov !== 1'b1 || cur_ir !== 1'b0 || cur_g !== g || cur_l !== l) hold_bad = 1'b1;
    end
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    if (cur_ov !== 1'b0 || cur_ir !== 1'b1 || cur_busy !== 1'b0 ||
        cur_g !== g || cur_l !== l) acc_bad = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || g8 !== 8'd0 || l8 !== 16'd0) begin
      errors++;
      $display("FAIL reset_outs: got ov=%0b busy=%0b gcd=%0d lcm=%0d expected 0 0 0 0", ov8, busy8, g8, l8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b/%0b expected 1/1", ir8, ir16);
    end
  endtask

  task automatic test_basic();
    logic [15:0] g; logic [31:0] l; int lat; bit to, bb, hb, ab;
    sel = 1'b0;
    run_op(16'd36, 16'd24, 0, g, l, lat, to, bb, hb, ab);
    checks++;
    if (to !== 1'b0 || g !== 16'd12 || l !== 32'd72) begin
      errors++;
      $display("FAIL basic_36_24: got to=%0b gcd=%0d lcm=%0d expected 0 12 72", to, g, l);
    end
    // 6 GCD cycles (5 steps + exit), 8 DIV, 1 MUL
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 15", lat);
    end
    checks++;
    if (bb !== 1'b0 || ab !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: got busy_bad=%0b acc_bad=%0b expected 0 0", bb, ab);
    end
  endtask

  task automatic test_vectors();
    int va[6] = '{255, 255, 128, 0, 0, 7};
    int vb[6] = '{254, 255, 64, 7, 0, 0};
    int vg[6] = '{1, 255, 64, 7, 0, 7};
    int vl[6] = '{64770, 255, 128, 0, 0, 0};
    logic [15:0] g; logic [31:0] l; int lat; bit to, bb, hb, ab;
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_op(16'(va[i]), 16'(vb[i]), 0, g, l, lat, to, bb, hb, ab);
      checks++;
      if (to !== 1'b0 || g !== 16'(vg[i]) || l !== 32'(vl[i]) || bb || ab) begin
        errors++;
        $display("FAIL vec a=%0d b=%0d: got gcd=%0d lcm=%0d to=%0b bb=%0b ab=%0b expected gcd=%0d lcm=%0d",
                 va[i], vb[i], g, l, to, bb, ab, vg[i], vl[i]);
      end
      // zero operand: exits on the first GCD cycle, no DIV/MUL
      checks++;
      if ((va[i] == 0 || vb[i] == 0) ? (lat !== 1) : (lat > 27)) begin
        errors++;
        $display("FAIL vec_latency a=%0d b=%0d: got %0d expected %s", va[i], vb[i], lat,
                 (va[i] == 0 || vb[i] == 0) ? "1" : "<=27");
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] g; logic [31:0] l; int lat; bit to, bb, hb, ab;
    sel = 1'b0;
    run_op(16'd36, 16'd24, 10, g, l, lat, to, bb, hb, ab);
    checks++;
    if (to || g !== 16'd12 || l !== 32'd72 || hb !== 1'b0) begin
      errors++;
      $display("FAIL hold_stable: got gcd=%0d lcm=%0d hold_bad=%0b expected 12 72 0", g, l, hb);
    end
    checks++;
    if (ab !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept: got acc_bad=%0b expected 0", ab);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [15:0] g; logic [31:0] l; int lat; bit to, bb, hb, ab;
    bit pulse;
    sel = 1'b0;
    drv_a = 16'd200; drv_b = 16'd150; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    // GCD exits after 6 cycles; 9 cycles in the engine is in DIV
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: got busy=%0b ov=%0b expected 1 0", busy8, ov8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1 || g8 !== 8'd0 || l8 !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%0b busy=%0b ir=%0b gcd=%0d lcm=%0d expected 0 0 1 0 0",
               ov8, busy8, ir8, g8, l8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) pulse = 1'b1;
    end
    checks++;
    if (pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_pulse: got out_valid pulse=%0b expected 0", pulse);
    end
    run_op(16'd36, 16'd24, 0, g, l, lat, to, bb, hb, ab);
    checks++;
    if (to || g !== 16'd12 || l !== 32'd72 || ab) begin
      errors++;
      $display("FAIL mid_after: got gcd=%0d lcm=%0d expected 12 72", g, l);
    end
  endtask

  task automatic test_gcd_only();
    logic [15:0] g; logic [31:0] l; int lat; bit to, bb, hb, ab;
    sel = 1'b1;
    run_op(16'd48000, 16'd36000, 0, g, l, lat, to, bb, hb, ab);
    checks++;
    if (to || g !== 16'd12000 || l !== 32'd0 || bb || ab) begin
      errors++;
      $display("FAIL gcd16: got gcd=%0d lcm=%0d to=%0b expected 12000 0", g, l, to);
    end
    checks++;
    if (lat > 34) begin
      errors++;
      $display("FAIL gcd16_latency: got %0d expected <=34", lat);
    end
    run_op(16'd0, 16'd5, 0, g, l, lat, to, bb, hb, ab);
    checks++;
    if (to || g !== 16'd5 || l !== 32'd0 || lat !== 1) begin
      errors++;
      $display("FAIL gcd16_zero: got gcd=%0d lcm=%0d lat=%0d expected 5 0 1", g, l, lat);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] a, b, eg, g; logic [31:0] el, l; int lat; bit to, bb, hb, ab;
    for (int cfg = 0; cfg < 2; cfg++) begin
      sel = (cfg == 1);
      for (int i = 0; i < 1000; i++) begin
        if (cfg == 0) begin
          a = 16'($urandom_range(0, 255));
          b = 16'($urandom_range(0, 255));
        end else begin
          a = 16'($urandom_range(0, 65535));
          b = 16'($urandom_range(0, 65535));
        end
        if (i % 97 == 0) a = 16'd0;
        run_op(a, b, 0, g, l, lat, to, bb, hb, ab);
        eg = ref_gcd(a, b);
        el = (cfg == 0) ? ref_lcm(a, b) : 32'd0;
        checks++;
        if (to || g !== eg || l !== el || bb || ab || lat > ((cfg == 0) ? 27 : 34)) begin
          errors++;
          $display("FAIL rand cfg=%0d a=%0d b=%0d: got gcd=%0d lcm=%0d lat=%0d to=%0b expected gcd=%0d lcm=%0d",
                   cfg, a, b, g, l, lat, to, eg, el);
        end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_hold();
    test_reset_mid_div();
    test_gcd_only();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
